gcd_master: RTL and testbench
=============================

GCD_MASTER -- requirements
Module: gcd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles spent in WAIT before the block abandons the job.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: the number of job-queue entries, a power of two.
REQ-003 SHALL have one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- job_valid_i  in  1  upstream job offered
- job_ready_o  out  1  queue can accept a job
- job_a_i  in  4  operand A of the job
- job_b_i  in  4  operand B of the job
- req_o  out  1  start request to the GCD engine
- op_a_o  out  4  operand A to the engine
- op_b_o  out  4  operand B to the engine
- busy_i  in  1  engine busy
- valid_i  in  1  engine result valid (1-cycle pulse)
- result_val_i  in  4  engine result
- res_valid_o  out  1  result available downstream
- res_ready_i  in  1  downstream accepts the result
- res_data_o  out  4  GCD result, or 0 on timeout
- res_timeout_o  out  1  result is a timeout
- jobs_done_o  out  8  count of successful jobs

Function
REQ-005 SHALL keep a FIFO of {a,b} pairs; job_ready_o = !full; a push occurs on job_valid_i && job_ready_o.
REQ-006 At full, job_ready_o SHALL be 0 even in a cycle that pops; a push is never accepted at full.
REQ-007 The FIFO SHALL pop only on the output handshake (res_valid_o && res_ready_i); the head entry stays in the queue until then.
REQ-008 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUTPUT.
REQ-009 IDLE -> ISSUE SHALL occur when the FIFO is non-empty and busy_i=0; the FSM SHALL remain in IDLE while the FIFO is empty or busy_i=1.
REQ-010 In ISSUE, req_o SHALL be 1 for exactly one cycle, with op_a_o/op_b_o equal to the FIFO head; the next state SHALL be WAIT.
REQ-011 op_a_o/op_b_o SHALL drive the FIFO head in every state and be stable from ISSUE through OUTPUT; req_o SHALL be 0 outside ISSUE.
REQ-012 In WAIT, a cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-013 In WAIT, valid_i=1 SHALL capture result_val_i into res_data_o, clear the timeout flag and go to OUTPUT.
REQ-014 In WAIT, if the counter reaches TIMEOUT_CYCLES-1 with valid_i=0, the block SHALL set res_data_o=0 and res_timeout_o=1 and go to OUTPUT.
REQ-015 If valid_i and the timeout coincide, valid_i SHALL win.
REQ-016 valid_i in IDLE, ISSUE or OUTPUT SHALL be ignored: no state change and no capture.
REQ-017 In OUTPUT, res_valid_o SHALL be 1, and res_data_o/res_timeout_o SHALL be held until res_ready_i; on the handshake the FSM SHALL pop and go to IDLE.
REQ-018 jobs_done_o SHALL increment on each handshake with res_timeout_o=0 and wrap from 255 to 0.
REQ-019 Minimum latency SHALL be: push at cycle 0, ISSUE at cycle 1 (FIFO registered, busy_i=0), WAIT from cycle 2, OUTPUT one cycle after valid_i.
REQ-020 Operands SHALL be passed unmodified; zero operands are legal, and the engine defines the result.

Reset
REQ-021 Asynchronous assertion of rst_ni=0 SHALL force state IDLE, empty FIFO, counter 0, and outputs req_o=0, res_valid_o=0, res_data_o=0, res_timeout_o=0, jobs_done_o=0, op_a_o=op_b_o=0 and job_ready_o=0.
REQ-022 After deassertion, job_ready_o SHALL be 1 on the first clock edge.
REQ-023 Reset mid-job SHALL discard the job with no output; a late valid_i after reset SHALL be ignored per REQ-016.

Verification
REQ-024 Push (12,8); engine model returns 4 after 5 cycles -> one req_o pulse with op_a_o=12 and op_b_o=8; res_valid_o, res_data_o=4, res_timeout_o=0; jobs_done_o=1.
REQ-025 Push 5 jobs back-to-back with the engine stalled busy_i=1 -> 4 accepted, job_ready_o=0 on the 5th; no req_o until busy_i=0.
REQ-026 Engine never asserts valid_i -> after 64 WAIT cycles: res_valid_o=1, res_data_o=0, res_timeout_o=1; jobs_done_o unchanged.
REQ-027 res_ready_i held 0 for 10 cycles in OUTPUT -> res_data_o stable, no second req_o; pop on the handshake, next job issued.
REQ-028 Pulse rst_ni low during WAIT, then the engine pulses valid_i -> all outputs 0, no res_valid_o, FIFO empty, job_ready_o=1.
REQ-029 Inject a stray valid_i in IDLE, then push 256 successful jobs -> no response to the stray pulse; jobs_done_o wraps to 0.

Source files
------------

// File: rtl/gcd_master.sv
// Job sequencer for an external GCD engine: queues {a,b} operand pairs, issues
// them one at a time, waits for the result or a timeout, and hands it downstream.
module gcd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       job_valid_i,
  output logic       job_ready_o,
  input  logic [3:0] job_a_i,
  input  logic [3:0] job_b_i,
  output logic       req_o,
  output logic [3:0] op_a_o,
  output logic [3:0] op_b_o,
  input  logic       busy_i,
  input  logic       valid_i,
  input  logic [3:0] result_val_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [3:0] res_data_o,
  output logic       res_timeout_o,
  output logic [7:0] jobs_done_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_live;
  logic [CW-1:0]   r_wait_cnt;
  logic [3:0]      r_res_data;
  logic            r_res_to;
  logic [7:0]      r_jobs_done;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_head;
  logic            w_capture;
  logic            w_expire;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // r_live keeps job_ready_o low while in reset and until the first clock edge after release.
  assign job_ready_o   = r_live & ~w_full;
  assign w_push        = job_valid_i & job_ready_o;
  assign res_valid_o   = (r_state == S_OUTPUT);
  assign w_pop         = res_valid_o & res_ready_i;
  assign req_o         = (r_state == S_ISSUE);
  assign op_a_o        = w_empty ? '0 : w_head[7:4];
  assign op_b_o        = w_empty ? '0 : w_head[3:0];
  assign res_data_o    = r_res_data;
  assign res_timeout_o = r_res_to;
  assign jobs_done_o   = r_jobs_done;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_empty && !busy_i) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last allowed cycle takes precedence over the timeout.
        if (valid_i) begin
          w_capture = 1'b1;
          w_next    = S_OUTPUT;
        end else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_expire = 1'b1;
          w_next   = S_OUTPUT;
        end
      end
      S_OUTPUT: if (res_ready_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {job_a_i, job_b_i};
        r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt  <= '0;
      r_res_data  <= '0;
      r_res_to    <= 1'b0;
      r_jobs_done <= '0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_capture) begin
        r_res_data <= result_val_i;
        r_res_to   <= 1'b0;
      end else if (w_expire) begin
        r_res_data <= '0;
        r_res_to   <= 1'b1;
      end
      if (w_pop && !r_res_to) begin
        r_jobs_done <= r_jobs_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcd_master.sv
// Self-checking bench for gcd_master: random jobs against a queue model and an
// arithmetic GCD reference, driven through a behavioural engine with programmable latency.
module tb_gcd_master;

  localparam int unsigned TO = 64;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       job_valid_i;
  logic       job_ready_o;
  logic [3:0] job_a_i;
  logic [3:0] job_b_i;
  logic       req_o;
  logic [3:0] op_a_o;
  logic [3:0] op_b_o;
  logic       busy_i;
  logic       valid_i;
  logic [3:0] result_val_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [3:0] res_data_o;
  logic       res_timeout_o;
  logic [7:0] jobs_done_o;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] q[$];
  logic [7:0] exp_done;

  logic       eng_stall;
  logic       eng_respond;
  int         eng_delay;
  int         eng_cnt;
  logic [3:0] eng_res;
  logic       eng_valid;
  logic       tb_valid;
  int         req_count = 0;

  always #5 clk_i = ~clk_i;

  gcd_master #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_a_i(job_a_i), .job_b_i(job_b_i),
    .req_o(req_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .busy_i(busy_i), .valid_i(valid_i), .result_val_i(result_val_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_timeout_o(res_timeout_o),
    .jobs_done_o(jobs_done_o)
  );

  function automatic logic [3:0] gcd_ref(input logic [3:0] a, input logic [3:0] b);
    int x = int'(a);
    int y = int'(b);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 4'(x);
  endfunction

  assign valid_i = eng_valid | tb_valid;
  assign busy_i  = eng_stall | (eng_cnt != 0);

  // Engine model: latches operands on req_o, answers eng_delay cycles later.
  initial begin
    eng_valid    = 1'b0;
    eng_cnt      = 0;
    eng_res      = '0;
    result_val_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      eng_valid = 1'b0;
      if (eng_cnt != 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          eng_valid    = 1'b1;
          result_val_i = eng_res;
        end
      end else if (req_o && eng_respond) begin
        eng_cnt = eng_delay;
        eng_res = gcd_ref(op_a_o, op_b_o);
      end
    end
  end

  always @(negedge clk_i) if (req_o) req_count++;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, output bit acc);
    acc = job_ready_o;
    job_a_i = a;
    job_b_i = b;
    job_valid_i = 1'b1;
    tick();
    job_valid_i = 1'b0;
    if (acc) q.push_back({a, b});
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_res(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid_o) begin
        ok = 1'b1;
        n  = i;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake(input bit to);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    void'(q.pop_front());
    if (!to) exp_done = exp_done + 8'd1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    tick();
    n_total++;
    if ({job_ready_o, req_o, res_valid_o, res_timeout_o, res_data_o, jobs_done_o, op_a_o, op_b_o} !== 24'h0)
      $display("FAIL reset_outputs: got %h want 000000",
               {job_ready_o, req_o, res_valid_o, res_timeout_o, res_data_o, jobs_done_o, op_a_o, op_b_o});
    else n_pass++;
    rst_ni = 1'b1;
    q.delete();
    exp_done = '0;
    n_total++;
    if (job_ready_o !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", job_ready_o);
    else n_pass++;
    tick();
    n_total++;
    if (job_ready_o !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", job_ready_o);
    else n_pass++;
  endtask

  task automatic test_basic;
    bit ok;
    bit acc;
    int n;
    int r0;
    eng_respond = 1'b1;
    eng_delay   = 5;
    r0 = req_count;
    push(4'd12, 4'd8, acc);
    n_total++;
    if (acc !== 1'b1) $display("FAIL basic_accept: got %b want 1", acc);
    else n_pass++;
    tick();
    n_total++;
    if ({req_o, op_a_o, op_b_o} !== {1'b1, 4'd12, 4'd8})
      $display("FAIL basic_issue: got req=%b a=%0d b=%0d want req=1 a=12 b=8", req_o, op_a_o, op_b_o);
    else n_pass++;
    tick();
    n_total++;
    if (req_o !== 1'b0) $display("FAIL basic_req_pulse: got %b want 0", req_o);
    else n_pass++;
    wait_res(ok, n);
    n_total++;
    if (!ok || n != 5) $display("FAIL basic_latency: got ok=%b n=%0d want ok=1 n=5", ok, n);
    else n_pass++;
    n_total++;
    if ({res_timeout_o, res_data_o} !== {1'b0, 4'd4})
      $display("FAIL basic_result: got to=%b data=%0d want to=0 data=4", res_timeout_o, res_data_o);
    else n_pass++;
    handshake(1'b0);
    n_total++;
    if ({jobs_done_o, res_valid_o} !== {8'd1, 1'b0} || req_count - r0 != 1)
      $display("FAIL basic_done: got done=%0d valid=%b reqs=%0d want done=1 valid=0 reqs=1",
               jobs_done_o, res_valid_o, req_count - r0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit acc;
    int n;
    int r0;
    int n_acc;
    logic [7:0] h;
    eng_respond = 1'b1;
    eng_stall   = 1'b1;
    r0 = req_count;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
      if (acc) n_acc++;
      if (i == 4) begin
        n_total++;
        if (acc !== 1'b0) $display("FAIL b2b_fifth_rejected: got %b want 0", acc);
        else n_pass++;
      end
    end
    n_total++;
    if (n_acc != 4) $display("FAIL b2b_accepted: got %0d want 4", n_acc);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (req_count != r0 || job_ready_o !== 1'b0)
      $display("FAIL b2b_stalled: got reqs=%0d ready=%b want reqs=0 ready=0", req_count - r0, job_ready_o);
    else n_pass++;
    eng_stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      eng_delay = $urandom_range(1, 8);
      h = q[0];
      wait_req(ok);
      n_total++;
      if (!ok || {op_a_o, op_b_o} !== h)
        $display("FAIL b2b_ops[%0d]: got ok=%b ops=%h want %h", j, ok, {op_a_o, op_b_o}, h);
      else n_pass++;
      wait_res(ok, n);
      n_total++;
      if (!ok || {res_timeout_o, res_data_o} !== {1'b0, gcd_ref(h[7:4], h[3:0])})
        $display("FAIL b2b_result[%0d]: got ok=%b to=%b data=%0d want %0d",
                 j, ok, res_timeout_o, res_data_o, gcd_ref(h[7:4], h[3:0]));
      else n_pass++;
      if (j == 0) begin
        // Full queue: a push offered in the popping cycle must be refused.
        n_total++;
        if (job_ready_o !== 1'b0) $display("FAIL b2b_full_pop_ready: got %b want 0", job_ready_o);
        else n_pass++;
        job_a_i = 4'd3;
        job_b_i = 4'd3;
        job_valid_i = 1'b1;
        handshake(1'b0);
        job_valid_i = 1'b0;
      end else begin
        repeat ($urandom_range(0, 2)) tick();
        handshake(1'b0);
      end
    end
    r0 = req_count;
    repeat (10) tick();
    n_total++;
    if (req_count != r0 || job_ready_o !== 1'b1 || jobs_done_o !== exp_done)
      $display("FAIL b2b_drained: got reqs=%0d ready=%b done=%0d want reqs=0 ready=1 done=%0d",
               req_count - r0, job_ready_o, jobs_done_o, exp_done);
    else n_pass++;
  endtask

  task automatic test_timeout;
    bit ok;
    bit acc;
    int n;
    eng_respond = 1'b0;
    push(4'd9, 4'd6, acc);
    wait_req(ok);
    wait_res(ok, n);
    n_total++;
    if (!ok || n != TO + 1) $display("FAIL timeout_cycles: got ok=%b n=%0d want %0d", ok, n, TO + 1);
    else n_pass++;
    n_total++;
    if ({res_timeout_o, res_data_o} !== {1'b1, 4'd0})
      $display("FAIL timeout_result: got to=%b data=%0d want to=1 data=0", res_timeout_o, res_data_o);
    else n_pass++;
    handshake(1'b1);
    n_total++;
    if (jobs_done_o !== exp_done) $display("FAIL timeout_done: got %0d want %0d", jobs_done_o, exp_done);
    else n_pass++;

    eng_respond = 1'b1;
    eng_delay   = TO;
    push(4'd15, 4'd10, acc);
    wait_req(ok);
    wait_res(ok, n);
    n_total++;
    if (!ok || {res_timeout_o, res_data_o} !== {1'b0, 4'd5})
      $display("FAIL valid_wins: got ok=%b to=%b data=%0d want to=0 data=5", ok, res_timeout_o, res_data_o);
    else n_pass++;
    handshake(1'b0);

    eng_delay = TO + 1;
    push(4'd14, 4'd7, acc);
    wait_req(ok);
    wait_res(ok, n);
    repeat (2) tick();
    n_total++;
    if (!ok || {res_valid_o, res_timeout_o, res_data_o} !== {1'b1, 1'b1, 4'd0})
      $display("FAIL late_valid_ignored: got ok=%b v=%b to=%b data=%0d want v=1 to=1 data=0",
               ok, res_valid_o, res_timeout_o, res_data_o);
    else n_pass++;
    handshake(1'b1);
    n_total++;
    if (jobs_done_o !== exp_done) $display("FAIL late_valid_done: got %0d want %0d", jobs_done_o, exp_done);
    else n_pass++;
  endtask

  task automatic test_output_hold;
    bit ok;
    bit acc;
    bit stable;
    int n;
    int r0;
    logic [3:0] d0;
    eng_respond = 1'b1;
    eng_delay   = 3;
    eng_stall   = 1'b1;
    r0 = req_count;
    push(4'd6, 4'd4, acc);
    push(4'd10, 4'd15, acc);
    eng_stall = 1'b0;
    wait_req(ok);
    wait_res(ok, n);
    n_total++;
    if (!ok || {res_timeout_o, res_data_o} !== {1'b0, 4'd2})
      $display("FAIL hold_result: got ok=%b to=%b data=%0d want data=2", ok, res_timeout_o, res_data_o);
    else n_pass++;
    d0 = res_data_o;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (res_valid_o !== 1'b1 || res_data_o !== d0) stable = 1'b0;
    end
    n_total++;
    if (!stable || req_count - r0 != 1)
      $display("FAIL hold_stable: got stable=%b reqs=%0d want stable=1 reqs=1", stable, req_count - r0);
    else n_pass++;
    handshake(1'b0);
    wait_req(ok);
    n_total++;
    if (!ok || {op_a_o, op_b_o} !== {4'd10, 4'd15})
      $display("FAIL hold_next_issue: got ok=%b a=%0d b=%0d want a=10 b=15", ok, op_a_o, op_b_o);
    else n_pass++;
    wait_res(ok, n);
    n_total++;
    if (!ok || res_data_o !== 4'd5) $display("FAIL hold_next_result: got ok=%b data=%0d want 5", ok, res_data_o);
    else n_pass++;
    handshake(1'b0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit acc;
    bit seen;
    int r0;
    eng_respond = 1'b1;
    eng_delay   = 10;
    push(4'd8, 4'd12, acc);
    wait_req(ok);
    repeat (3) tick();
    #1;
    rst_ni = 1'b0;
    #1;
    n_total++;
    if ({job_ready_o, req_o, res_valid_o, res_timeout_o, res_data_o, jobs_done_o, op_a_o, op_b_o} !== 24'h0)
      $display("FAIL midreset_async: got %h want 000000",
               {job_ready_o, req_o, res_valid_o, res_timeout_o, res_data_o, jobs_done_o, op_a_o, op_b_o});
    else n_pass++;
    tick();
    rst_ni = 1'b1;
    q.delete();
    exp_done = '0;
    r0 = req_count;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (res_valid_o) seen = 1'b1;
    end
    n_total++;
    if (seen || req_count != r0)
      $display("FAIL midreset_no_output: got seen=%b reqs=%0d want seen=0 reqs=0", seen, req_count - r0);
    else n_pass++;
    n_total++;
    if ({job_ready_o, jobs_done_o, res_timeout_o, res_data_o} !== {1'b1, 13'h0})
      $display("FAIL midreset_state: got ready=%b done=%0d to=%b data=%0d want ready=1 rest 0",
               job_ready_o, jobs_done_o, res_timeout_o, res_data_o);
    else n_pass++;
  endtask

  task automatic test_wrap;
    bit ok;
    bit acc;
    int n;
    logic [7:0] h;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    tick();
    n_total++;
    if ({res_valid_o, req_o, res_data_o} !== 6'h0)
      $display("FAIL stray_valid: got v=%b req=%b data=%0d want all 0", res_valid_o, req_o, res_data_o);
    else n_pass++;
    eng_respond = 1'b1;
    for (int i = 0; i < 256; i++) begin
      eng_delay = $urandom_range(1, 3);
      push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
      h = q[0];
      wait_req(ok);
      n_total++;
      if (!ok || {op_a_o, op_b_o} !== h)
        $display("FAIL wrap_ops[%0d]: got ok=%b ops=%h want %h", i, ok, {op_a_o, op_b_o}, h);
      else n_pass++;
      wait_res(ok, n);
      n_total++;
      if (!ok || {res_timeout_o, res_data_o} !== {1'b0, gcd_ref(h[7:4], h[3:0])})
        $display("FAIL wrap_result[%0d]: got ok=%b to=%b data=%0d want %0d",
                 i, ok, res_timeout_o, res_data_o, gcd_ref(h[7:4], h[3:0]));
      else n_pass++;
      handshake(1'b0);
      if (i == 254) begin
        n_total++;
        if (jobs_done_o !== 8'd255) $display("FAIL wrap_255: got %0d want 255", jobs_done_o);
        else n_pass++;
      end
    end
    n_total++;
    if (jobs_done_o !== exp_done || exp_done !== 8'd0)
      $display("FAIL wrap_zero: got %0d want %0d", jobs_done_o, exp_done);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    job_valid_i = 1'b0;
    job_a_i     = '0;
    job_b_i     = '0;
    res_ready_i = 1'b0;
    tb_valid    = 1'b0;
    eng_stall   = 1'b0;
    eng_respond = 1'b1;
    eng_delay   = 1;
    exp_done    = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_output_hold();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
